// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
//
// Parametrised UART transmitter. Each character is taken in by a valid/ready
// handshake and sent as one frame, least-significant data bit first:
//   start (0) | DATA_BITS data | optional parity | STOP_BITS stop (1)
// Every bit lasts CLKS_PER_BIT clocks. The serial line idles at mark (1).
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit (>= 2)
//   DATA_BITS     data bits per character (5..9)
//   PARITY        0 = none, 1 = even, 2 = odd
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   clk_3125k   in   system clock, rising edge
//   rst         in   synchronous active-high reset; aborts any frame
//   data_in     in   [DATA_BITS-1:0] character to send
//   data_valid  in   data_in is valid
//   data_ready  out  character can be accepted this cycle (combinational)
//   tx          out  serial line (registered)
//   busy        out  a frame (or break) is in progress
//   break_req   in   only when UART_TX_BREAK_EN is defined
//
// Optional feature, macro UART_TX_BREAK_EN: adds break_req. A break request
// seen in IDLE drives the line low for at least one frame time (longer while
// break_req stays high), followed by a single mark cycle before IDLE. A
// request that arrives mid-frame waits until the frame completes, and a
// break request beats a simultaneous character.
// ---------------------------------------------------------------------------
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 27,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_3125k,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 tx,
  output logic                 busy
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                 break_req
`endif
);

  // Reject illegal configurations at elaboration instead of clamping them.
  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

`ifdef UART_TX_BREAK_EN
  localparam int FRAME_CLKS =
    CLKS_PER_BIT * (1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS);
  localparam int             BRK_W    = $clog2(FRAME_CLKS);
  localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(FRAME_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BREAK    = 3'd5,
    S_BRK_MARK = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`endif

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_tx;
  logic                   w_tx_next;
  logic [BAUD_W-1:0]      r_baud_cnt;
  logic [3:0]             r_bit_cnt;     // data-bit index, then stop-bit index
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_parity;
  logic                   w_accept;
  logic                   w_baud_wrap;
`ifdef UART_TX_BREAK_EN
  logic [BRK_W-1:0]       r_brk_cnt;     // saturates at one frame time
  logic                   w_brk_done;
`endif

  assign w_accept    = data_valid && data_ready;
  assign w_baud_wrap = (r_baud_cnt == BAUD_LAST);
  assign tx          = r_tx;

`ifdef UART_TX_BREAK_EN
  assign w_brk_done = (r_brk_cnt == BRK_LAST) && !break_req;
`endif

  // -------------------------------------------------------------------------
  // State register (tx is registered alongside the state)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_3125k) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_START;
`ifdef UART_TX_BREAK_EN
        // data_ready is held low by break_req, so this never collides
        // with an acceptance.
        if (break_req) w_state_next = S_BREAK;
`endif
      end
      S_START: begin
        if (w_baud_wrap) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_baud_wrap && (r_bit_cnt == DATA_LAST)) begin
          w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_baud_wrap) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_baud_wrap && (r_bit_cnt == STOP_LAST)) w_state_next = S_IDLE;
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (w_brk_done) w_state_next = S_BRK_MARK;
      end
      S_BRK_MARK: begin
        w_state_next = S_IDLE;
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: handshake/busy flags and the next line level
  // -------------------------------------------------------------------------
  always_comb begin
    busy       = (r_state != S_IDLE);
`ifdef UART_TX_BREAK_EN
    data_ready = (r_state == S_IDLE) && !rst && !break_req;
`else
    data_ready = (r_state == S_IDLE) && !rst;
`endif
    w_tx_next  = r_tx;
    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (w_accept) w_tx_next = 1'b0;
`ifdef UART_TX_BREAK_EN
        if (break_req) w_tx_next = 1'b0;
`endif
      end
      S_START: begin
        // r_shift[0] is still data bit 0 here; it is shifted on this wrap.
        if (w_baud_wrap) w_tx_next = r_shift[0];
      end
      S_DATA: begin
        if (w_baud_wrap) begin
          if (r_bit_cnt == DATA_LAST) begin
            w_tx_next = (PARITY != 0) ? r_parity : 1'b1;
          end else begin
            w_tx_next = r_shift[0];
          end
        end
      end
      S_PARITY: begin
        if (w_baud_wrap) w_tx_next = 1'b1;
      end
      S_STOP: begin
        w_tx_next = 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        w_tx_next = w_brk_done ? 1'b1 : 1'b0;
      end
      S_BRK_MARK: begin
        w_tx_next = 1'b1;
      end
`endif
      default: begin
        w_tx_next = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: baud counter, bit counter, shift register, parity
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_3125k) begin
    if (rst) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud_cnt <= '0;
          r_bit_cnt  <= '0;
          if (w_accept) begin
            r_shift  <= data_in;
            // Even parity is the XOR of the data bits; odd is its inverse.
            r_parity <= (^data_in) ^ (PARITY == 2);
          end
        end
        S_START, S_DATA, S_PARITY, S_STOP: begin
          r_baud_cnt <= w_baud_wrap ? '0 : r_baud_cnt + 1'b1;
          if (w_baud_wrap) begin
            // Shift so that r_shift[0] always holds the next bit to send.
            if (r_state == S_START) begin
              r_shift <= r_shift >> 1;
            end
            if (r_state == S_DATA) begin
              if (r_bit_cnt == DATA_LAST) begin
                r_bit_cnt <= '0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_shift   <= r_shift >> 1;
              end
            end
            if (r_state == S_STOP) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_baud_cnt <= '0;
          r_bit_cnt  <= '0;
        end
      endcase
    end
  end

`ifdef UART_TX_BREAK_EN
  // Counts cycles spent in BREAK so the line stays low for at least a frame.
  always_ff @(posedge clk_3125k) begin
    if (rst || (r_state != S_BREAK)) begin
      r_brk_cnt <= '0;
    end else if (r_brk_cnt != BRK_LAST) begin
      r_brk_cnt <= r_brk_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_param
//
// Five instances of uart_tx_param with different configurations share one
// clock, one reset and one data bus. A frame model builds the expected bit
// list for each character (start, LSB-first data, parity by ones-count,
// stop bits); the line is sampled every cycle on the falling edge and each
// bit must hold its level for exactly CLKS_PER_BIT cycles.
// ---------------------------------------------------------------------------
module tb_uart_tx_param;

  localparam int NDUT = 5;

  int cpb_of [NDUT] = '{27, 27, 27, 27, 2};
  int db_of  [NDUT] = '{8,  8,  8,  7,  9};
  int par_of [NDUT] = '{0,  1,  2,  0,  2};
  int sb_of  [NDUT] = '{1,  1,  1,  2,  2};

  logic            clk = 1'b0;
  logic            rst;
  logic [8:0]      data_bus;
  logic [NDUT-1:0] valid_v;
  logic [NDUT-1:0] ready_v;
  logic [NDUT-1:0] tx_v;
  logic [NDUT-1:0] busy_v;
`ifdef UART_TX_BREAK_EN
  logic            brk;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_bits[$];

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(27), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk_3125k (clk),
    .rst       (rst),
    .data_in   (data_bus[7:0]),
    .data_valid(valid_v[0]),
    .data_ready(ready_v[0]),
    .tx        (tx_v[0]),
    .busy      (busy_v[0])
`ifdef UART_TX_BREAK_EN
    ,
    .break_req (brk)
`endif
  );

  uart_tx_param #(.CLKS_PER_BIT(27), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clk_3125k (clk),
    .rst       (rst),
    .data_in   (data_bus[7:0]),
    .data_valid(valid_v[1]),
    .data_ready(ready_v[1]),
    .tx        (tx_v[1]),
    .busy      (busy_v[1])
`ifdef UART_TX_BREAK_EN
    ,
    .break_req (1'b0)
`endif
  );

  uart_tx_param #(.CLKS_PER_BIT(27), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut2 (
    .clk_3125k (clk),
    .rst       (rst),
    .data_in   (data_bus[7:0]),
    .data_valid(valid_v[2]),
    .data_ready(ready_v[2]),
    .tx        (tx_v[2]),
    .busy      (busy_v[2])
`ifdef UART_TX_BREAK_EN
    ,
    .break_req (1'b0)
`endif
  );

  uart_tx_param #(.CLKS_PER_BIT(27), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk_3125k (clk),
    .rst       (rst),
    .data_in   (data_bus[6:0]),
    .data_valid(valid_v[3]),
    .data_ready(ready_v[3]),
    .tx        (tx_v[3]),
    .busy      (busy_v[3])
`ifdef UART_TX_BREAK_EN
    ,
    .break_req (1'b0)
`endif
  );

  uart_tx_param #(.CLKS_PER_BIT(2), .DATA_BITS(9), .PARITY(2), .STOP_BITS(2)) u_dut4 (
    .clk_3125k (clk),
    .rst       (rst),
    .data_in   (data_bus[8:0]),
    .data_valid(valid_v[4]),
    .data_ready(ready_v[4]),
    .tx        (tx_v[4]),
    .busy      (busy_v[4])
`ifdef UART_TX_BREAK_EN
    ,
    .break_req (1'b0)
`endif
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame: start, data LSB first, parity from ones count, stops.
  function automatic void build_frame(input int d, input logic [8:0] val);
    int ones;
    exp_bits.delete();
    ones = 0;
    exp_bits.push_back(0);
    for (int i = 0; i < db_of[d]; i++) begin
      exp_bits.push_back(int'(val[i]));
      ones += int'(val[i]);
    end
    if (par_of[d] == 1) exp_bits.push_back(ones % 2);
    else if (par_of[d] == 2) exp_bits.push_back(1 - (ones % 2));
    for (int i = 0; i < sb_of[d]; i++) exp_bits.push_back(1);
  endfunction

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    while (ready_v[d] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check_value($sformatf("d%0d_ready_timeout", d), 32'd0, 32'd1);
  endtask

  // Send one character and check the whole frame cycle by cycle. With noisy
  // set, data_valid/data_in toggle randomly while the frame is running.
  task automatic send_and_check(input int d, input logic [8:0] val, input bit noisy);
    int f;
    int busy_cnt;
    int nready_cnt;
    int hits;
    int bad_bits;
    logic eb;
    wait_ready(d);
    build_frame(d, val);
    f = exp_bits.size() * cpb_of[d];
    data_bus   = val;
    valid_v[d] = 1'b1;
    @(negedge clk);
    valid_v[d] = 1'b0;
    data_bus   = 9'($urandom);
    busy_cnt   = 0;
    nready_cnt = 0;
    bad_bits   = 0;
    for (int b = 0; b < exp_bits.size(); b++) begin
      hits = 0;
      eb = (exp_bits[b] != 0);
      for (int c = 0; c < cpb_of[d]; c++) begin
        if (tx_v[d] === eb) hits++;
        if (busy_v[d] === 1'b1) busy_cnt++;
        if (ready_v[d] === 1'b0) nready_cnt++;
        if (noisy) begin
          valid_v[d] = 1'($urandom_range(0, 1));
          data_bus   = 9'($urandom);
        end
        @(negedge clk);
      end
      if (hits != cpb_of[d]) bad_bits++;
      check_value($sformatf("d%0d_bit%0d_cycles", d, b), hits, cpb_of[d]);
    end
    valid_v[d] = 1'b0;
    check_value($sformatf("d%0d_busy_cycles", d), busy_cnt, f);
    check_value($sformatf("d%0d_notready_cycles", d), nready_cnt, f);
    check_value($sformatf("d%0d_idle_tx", d), 32'(tx_v[d]), 32'd1);
    check_value($sformatf("d%0d_idle_busy", d), 32'(busy_v[d]), 32'd0);
    check_value($sformatf("d%0d_idle_ready", d), 32'(ready_v[d]), 32'd1);
    $display("tx dut=%0d data=%03h frame=%0d cycles bad_bits=%0d noisy=%0d",
             d, val, f, bad_bits, noisy);
  endtask

  // Two characters with data_valid held high: check spacing and content.
  task automatic back_to_back();
    logic cap[$];
    logic acc;
    int   n_acc;
    int   f;
    int   idx2;
    logic [8:0] v1;
    logic [8:0] v2;
    f = 10 * 27;
    n_acc = 0;
    wait_ready(0);
    data_bus   = 9'h055;
    valid_v[0] = 1'b1;
    for (int cyc = 0; cyc < 2 * f + 20; cyc++) begin
      acc = ready_v[0] && valid_v[0];
      @(negedge clk);
      if (acc) begin
        n_acc++;
        if (n_acc == 1) data_bus = 9'h0AA;
        else valid_v[0] = 1'b0;
      end
      cap.push_back(tx_v[0]);
    end
    valid_v[0] = 1'b0;
    check_value("b2b_accepts", n_acc, 2);
    check_value("b2b_first_start", 32'(cap[0]), 32'd0);
    idx2 = -1;
    for (int i = f; i < cap.size(); i++) begin
      if (idx2 < 0 && cap[i-1] === 1'b1 && cap[i] === 1'b0) idx2 = i;
    end
    check_value("b2b_fall_spacing", idx2, f + 1);
    v1 = '0;
    v2 = '0;
    if (idx2 > 0 && idx2 + f <= cap.size()) begin
      for (int i = 0; i < 8; i++) begin
        v1[i] = cap[(1 + i) * 27 + 13];
        v2[i] = cap[idx2 + (1 + i) * 27 + 13];
      end
    end
    check_value("b2b_char1", v1, 9'h055);
    check_value("b2b_char2", v2, 9'h0AA);
    $display("b2b spacing=%0d char1=%02h char2=%02h", idx2, v1, v2);
  endtask

  // Reset pulse at cycle 100 of an 8'hFF frame, then a clean 8'h00.
  task automatic reset_mid_frame();
    wait_ready(0);
    data_bus   = 9'h0FF;
    valid_v[0] = 1'b1;
    @(negedge clk);
    valid_v[0] = 1'b0;
    repeat (99) @(negedge clk);
    check_value("rst_busy_before", 32'(busy_v[0]), 32'd1);
    rst = 1'b1;
    #1;
    check_value("rst_ready_low", 32'(ready_v[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_value("rst_tx_mark", 32'(tx_v[0]), 32'd1);
    check_value("rst_busy_low", 32'(busy_v[0]), 32'd0);
    check_value("rst_ready_high", 32'(ready_v[0]), 32'd1);
    $display("reset mid-frame tx=%0b busy=%0b ready=%0b", tx_v[0], busy_v[0], ready_v[0]);
    send_and_check(0, 9'h000, 1'b0);
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic break_test();
    int low;
    int c;
    int stray;
    wait_ready(0);
    brk        = 1'b1;
    valid_v[0] = 1'b1;
    data_bus   = 9'h03C;
    #1;
    check_value("brk_ready_low", 32'(ready_v[0]), 32'd0);
    @(negedge clk);
    low = 0;
    c   = 0;
    while (tx_v[0] === 1'b0 && c < 1000) begin
      low++;
      c++;
      if (c == 10) begin
        brk        = 1'b0;
        valid_v[0] = 1'b0;
      end
      @(negedge clk);
    end
    brk        = 1'b0;
    valid_v[0] = 1'b0;
    check_value("brk_low_cycles", low, 270);
    check_value("brk_mark_tx", 32'(tx_v[0]), 32'd1);
    check_value("brk_mark_ready", 32'(ready_v[0]), 32'd0);
    @(negedge clk);
    check_value("brk_after_ready", 32'(ready_v[0]), 32'd1);
    stray = 0;
    repeat (30) begin
      if (tx_v[0] !== 1'b1) stray++;
      @(negedge clk);
    end
    check_value("brk_no_char", stray, 0);
    $display("break low=%0d stray=%0d", low, stray);
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    valid_v  = '0;
    data_bus = '0;
`ifdef UART_TX_BREAK_EN
    brk      = 1'b0;
`endif
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check_value($sformatf("d%0d_rst_tx", d), 32'(tx_v[d]), 32'd1);
      check_value($sformatf("d%0d_rst_busy", d), 32'(busy_v[d]), 32'd0);
      check_value($sformatf("d%0d_rst_ready", d), 32'(ready_v[d]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check_value($sformatf("d%0d_post_rst_ready", d), 32'(ready_v[d]), 32'd1);
    end

    // Directed characters from the frame rules.
    send_and_check(0, 9'h0A5, 1'b0);
    send_and_check(1, 9'h007, 1'b0);
    send_and_check(2, 9'h007, 1'b0);
    send_and_check(3, 9'h041, 1'b0);
    send_and_check(4, 9'h1FF, 1'b0);

    back_to_back();
    reset_mid_frame();

    // Randomized characters, gaps and in-frame valid noise.
    for (int d = 0; d < NDUT; d++) begin
      repeat (6) begin
        send_and_check(d, 9'($urandom), 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

`ifdef UART_TX_BREAK_EN
    break_test();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
